// File: rtl/vending_engine.sv
// Vending machine engine: four-phase operation sequencer over per-slot
// stock and price tables, a bank balance, and change/withdraw outputs.
module vending_engine #(
    parameter int N_PROD     = 8,
    parameter int PID_W      = 3,
    parameter int MONEY_W    = 8,
    parameter int QTY_W      = 4,
    parameter int STOCK_W    = 4,
    parameter int BANK_W     = 12,
    parameter int INIT_STOCK = 5,
    parameter int INIT_PRICE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [PID_W-1:0]   product_id,
    input  logic [QTY_W-1:0]   quantity,
    input  logic [MONEY_W-1:0] data_in,
    output logic               busy,
    output logic               done,
    output logic               red_light,
    output logic [MONEY_W-1:0] change_out,
    output logic [BANK_W-1:0]  withdraw_out,
    output logic [BANK_W-1:0]  machine_money,
    output logic [STOCK_W-1:0] stock_out
);

    localparam int CW = MONEY_W + QTY_W;
    localparam int XW = ((BANK_W > CW) ? BANK_W : CW) + 1;
    localparam int QS = (STOCK_W > QTY_W) ? STOCK_W : QTY_W;
    localparam logic [PID_W:0] NP = (PID_W+1)'(N_PROD);

    localparam logic [1:0] M_CUST = 2'b00;
    localparam logic [1:0] M_WDR  = 2'b01;
    localparam logic [1:0] M_SUP  = 2'b10;
    localparam logic [1:0] M_PRC  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_DONE} state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [PID_W-1:0]   id_q;
    logic [QTY_W-1:0]   qty_q;
    logic [MONEY_W-1:0] data_q;
    logic               err_q;
    logic [MONEY_W-1:0] chg_q;
    logic [BANK_W-1:0]  bank_nx_q;
    logic [STOCK_W-1:0] stk_nx_q;
    logic               busy_q;
    logic               done_q;
    logic               red_q;
    logic [MONEY_W-1:0] change_q;
    logic [BANK_W-1:0]  wdr_q;
    logic [BANK_W-1:0]  bank_q;
    logic [STOCK_W-1:0] stock_q [N_PROD];
    logic [MONEY_W-1:0] price_q [N_PROD];

    logic               id_ok;
    logic [PID_W-1:0]   idx;
    logic [STOCK_W-1:0] cur_stock;
    logic [MONEY_W-1:0] cur_price;
    logic [STOCK_W-1:0] amount;
    logic [CW-1:0]      cost_d;
    logic [XW-1:0]      bank_sum;
    logic [XW-1:0]      bank_max;
    logic [STOCK_W:0]   stock_sum;
    logic               err_d;
    logic [MONEY_W-1:0] chg_d;
    logic [STOCK_W-1:0] stk_nx_d;

    // Cost and error evaluation for the latched operation; an invalid
    // slot is forced onto slot 0 so the table reads stay in range.
    always_comb begin
        id_ok     = {1'b0, id_q} < NP;
        idx       = id_ok ? id_q : '0;
        cur_stock = stock_q[idx];
        cur_price = price_q[idx];
        amount    = data_q[STOCK_W-1:0];
        cost_d    = CW'(cur_price) * CW'(qty_q);
        bank_sum  = XW'(bank_q) + XW'(cost_d);
        bank_max  = {{(XW-BANK_W){1'b0}}, {BANK_W{1'b1}}};
        stock_sum = {1'b0, cur_stock} + {1'b0, amount};
        chg_d     = data_q - cost_d[MONEY_W-1:0];
        stk_nx_d  = stock_sum[STOCK_W-1:0];
        err_d     = 1'b0;
        unique case (mode_q)
            M_CUST: begin
                err_d = !id_ok || (qty_q == '0)
                     || (QS'(cur_stock) < QS'(qty_q))
                     || (cost_d > CW'(data_q))
                     || (bank_sum > bank_max);
                stk_nx_d = cur_stock - STOCK_W'(qty_q);
            end
            M_WDR:   err_d = (bank_q == '0);
            M_SUP:   err_d = !id_ok || (amount == '0) || stock_sum[STOCK_W];
            M_PRC:   err_d = !id_ok || (data_q == '0);
            default: err_d = 1'b1;
        endcase
    end

    // Operation sequencer with registered status outputs and table updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            id_q      <= '0;
            qty_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            chg_q     <= '0;
            bank_nx_q <= '0;
            stk_nx_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            red_q     <= 1'b0;
            change_q  <= '0;
            wdr_q     <= '0;
            bank_q    <= '0;
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
                price_q[i] <= MONEY_W'(INIT_PRICE);
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        id_q    <= product_id;
                        qty_q   <= quantity;
                        data_q  <= data_in;
                        busy_q  <= 1'b1;
                        red_q   <= 1'b0;
                        state_q <= S_CHECK;
                        if (mode != M_WDR) wdr_q <= '0;
                    end
                end
                S_CHECK: begin
                    err_q     <= err_d;
                    chg_q     <= chg_d;
                    bank_nx_q <= bank_sum[BANK_W-1:0];
                    stk_nx_q  <= stk_nx_d;
                    state_q   <= S_COMMIT;
                end
                S_COMMIT: begin
                    red_q   <= err_q;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                    if (err_q) begin
                        if (mode_q == M_CUST) change_q <= data_q;
                    end else begin
                        unique case (mode_q)
                            M_CUST: begin
                                stock_q[idx] <= stk_nx_q;
                                bank_q       <= bank_nx_q;
                                change_q     <= chg_q;
                            end
                            M_WDR: begin
                                wdr_q  <= bank_q;
                                bank_q <= '0;
                            end
                            M_SUP:   stock_q[idx] <= stk_nx_q;
                            M_PRC:   price_q[idx] <= data_q;
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign red_light     = red_q;
    assign change_out    = change_q;
    assign withdraw_out  = wdr_q;
    assign machine_money = bank_q;
    assign stock_out     = ({1'b0, product_id} < NP) ? stock_q[product_id] : '0;

endmodule
